// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU encodings: flag commands, ALU operations, status byte layout
package cpu_pkg;

    typedef enum logic [3:0] {
        FOP_NOP     = 4'd0,
        FOP_LD_NZ   = 4'd1,
        FOP_LD_NZC  = 4'd2,
        FOP_LD_NZCV = 4'd3,
        FOP_LD_BIT  = 4'd4,
        FOP_LD_P    = 4'd5,
        FOP_SEC     = 4'd6,
        FOP_CLC     = 4'd7,
        FOP_SED     = 4'd8,
        FOP_CLD     = 4'd9,
        FOP_SEI     = 4'd10,
        FOP_CLI     = 4'd11,
        FOP_CLV     = 4'd12
    } flag_op_e;

    typedef enum logic [3:0] {
        ALU_ADC  = 4'd0,
        ALU_SBC  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_ORA  = 4'd3,
        ALU_EOR  = 4'd4,
        ALU_ASL  = 4'd5,
        ALU_LSR  = 4'd6,
        ALU_ROL  = 4'd7,
        ALU_ROR  = 4'd8,
        ALU_INC  = 4'd9,
        ALU_DEC  = 4'd10,
        ALU_PASS = 4'd11
    } alu_op_e;

    localparam int P_N = 7;
    localparam int P_V = 6;
    localparam int P_D = 3;
    localparam int P_I = 2;
    localparam int P_Z = 1;
    localparam int P_C = 0;

    // Bit 5 always reads 1; bit 4 is the B value supplied by whoever pushes
    localparam logic [7:0] P_RESET = 8'h24;

    function automatic logic [7:0] pack_p(input logic n, input logic v, input logic b,
                                          input logic d, input logic i, input logic z,
                                          input logic c);
        return {n, v, 1'b1, b, d, i, z, c};
    endfunction

endpackage

// File: rtl/int_ctl.sv
// rtl/int_ctl.sv - NMI edge capture, delayed IRQ mask and interrupt request arbitration
module int_ctl
    import cpu_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_nmi_n,
    input  logic i_irq_n,
    input  logic i_sync,
    input  logic i_int_ack,
    input  logic i_flag_i,
    output logic o_int_req,
    output logic o_int_src
);

    logic r_nmi_q;
    logic r_nmi_mask;
    logic r_nmi_pend;
    logic r_i_eff;
    logic w_nmi_edge;

    // The mask swallows the apparent edge when NMI_N was already low at the last reset edge
    assign w_nmi_edge = r_nmi_q & ~i_nmi_n & ~r_nmi_mask;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_nmi_q    <= 1'b1;
            r_nmi_mask <= ~i_nmi_n;
            r_nmi_pend <= 1'b0;
            r_i_eff    <= P_RESET[P_I];
        end else begin
            r_nmi_q    <= i_nmi_n;
            r_nmi_mask <= 1'b0;
            if (w_nmi_edge)
                r_nmi_pend <= 1'b1;
            else if (i_int_ack && r_nmi_pend)
                r_nmi_pend <= 1'b0;
            if (i_int_ack)
                r_i_eff <= 1'b1;
            else if (i_sync)
                r_i_eff <= i_flag_i;
        end
    end

    assign o_int_src = r_nmi_pend;
    assign o_int_req = r_nmi_pend | (~i_irq_n & ~r_i_eff);

endmodule

// File: rtl/status_reg.sv
// rtl/status_reg.sv - processor status flags with interrupt control; STATUS_DECIMAL_EN enables the D flag
module status_reg
    import cpu_pkg::*;
(
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       ALU_N,
    input  logic       ALU_Z,
    input  logic       ALU_C,
    input  logic       ALU_V,
    input  logic [7:0] DB_IN,
    input  logic [3:0] OP,
    input  logic       PUSH_B,
    input  logic       SYNC,
    input  logic       NMI_N,
    input  logic       IRQ_N,
    input  logic       INT_ACK,
    output logic [7:0] P_OUT,
    output logic       C_OUT,
    output logic       D_OUT,
    output logic       I_OUT,
    output logic       INT_REQ,
    output logic       INT_SRC
);

    logic r_n, r_v, r_i, r_z, r_c;
    logic w_d;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_n <= P_RESET[P_N];
            r_v <= P_RESET[P_V];
            r_i <= P_RESET[P_I];
            r_z <= P_RESET[P_Z];
            r_c <= P_RESET[P_C];
        end else begin
            case (OP)
                FOP_LD_NZ:   begin r_n <= ALU_N; r_z <= ALU_Z; end
                FOP_LD_NZC:  begin r_n <= ALU_N; r_z <= ALU_Z; r_c <= ALU_C; end
                FOP_LD_NZCV: begin r_n <= ALU_N; r_z <= ALU_Z; r_c <= ALU_C; r_v <= ALU_V; end
                FOP_LD_BIT:  begin r_n <= DB_IN[7]; r_v <= DB_IN[6]; r_z <= ALU_Z; end
                FOP_LD_P: begin
                    r_n <= DB_IN[P_N];
                    r_v <= DB_IN[P_V];
                    r_i <= DB_IN[P_I];
                    r_z <= DB_IN[P_Z];
                    r_c <= DB_IN[P_C];
                end
                FOP_SEC: r_c <= 1'b1;
                FOP_CLC: r_c <= 1'b0;
                FOP_SEI: r_i <= 1'b1;
                FOP_CLI: r_i <= 1'b0;
                FOP_CLV: r_v <= 1'b0;
                default: ;
            endcase
            // Interrupt entry masks IRQs regardless of what the same-cycle command did to I
            if (INT_ACK)
                r_i <= 1'b1;
        end
    end

`ifdef STATUS_DECIMAL_EN
    logic r_d;

    always_ff @(posedge CLK) begin
        if (!RST_N)
            r_d <= P_RESET[P_D];
        else if (OP == FOP_SED)
            r_d <= 1'b1;
        else if (OP == FOP_CLD)
            r_d <= 1'b0;
        else if (OP == FOP_LD_P)
            r_d <= DB_IN[P_D];
    end

    assign w_d = r_d;
`else
    assign w_d = 1'b0;
`endif

    int_ctl u_int_ctl (
        .i_clk     (CLK),
        .i_rst_n   (RST_N),
        .i_nmi_n   (NMI_N),
        .i_irq_n   (IRQ_N),
        .i_sync    (SYNC),
        .i_int_ack (INT_ACK),
        .i_flag_i  (r_i),
        .o_int_req (INT_REQ),
        .o_int_src (INT_SRC)
    );

    assign P_OUT = pack_p(r_n, r_v, PUSH_B, w_d, r_i, r_z, r_c);
    assign C_OUT = r_c;
    assign D_OUT = w_d;
    assign I_OUT = r_i;

endmodule

// File: tb/tb_status_reg.sv
// tb/tb_status_reg.sv - scoreboard bench for status_reg with directed and random stimulus
module tb_status_reg;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       ALU_N = 1'b0, ALU_Z = 1'b0, ALU_C = 1'b0, ALU_V = 1'b0;
    logic [7:0] DB_IN = 8'h00;
    logic [3:0] OP = 4'd0;
    logic       PUSH_B = 1'b0, SYNC = 1'b0, NMI_N = 1'b1, IRQ_N = 1'b1, INT_ACK = 1'b0;
    logic [7:0] P_OUT;
    logic       C_OUT, D_OUT, I_OUT, INT_REQ, INT_SRC;

    status_reg dut (
        .CLK(CLK), .RST_N(RST_N),
        .ALU_N(ALU_N), .ALU_Z(ALU_Z), .ALU_C(ALU_C), .ALU_V(ALU_V),
        .DB_IN(DB_IN), .OP(OP), .PUSH_B(PUSH_B), .SYNC(SYNC),
        .NMI_N(NMI_N), .IRQ_N(IRQ_N), .INT_ACK(INT_ACK),
        .P_OUT(P_OUT), .C_OUT(C_OUT), .D_OUT(D_OUT), .I_OUT(I_OUT),
        .INT_REQ(INT_REQ), .INT_SRC(INT_SRC)
    );

    always #5 CLK = ~CLK;

`ifdef STATUS_DECIMAL_EN
    localparam bit DEC = 1'b1;
`else
    localparam bit DEC = 1'b0;
`endif

    typedef struct {
        logic [7:0] p;
        logic       c, d, i, req, src;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    bit   stim_done = 1'b0;

    // Reference state: status byte image, effective mask, pending NMI, last NMI level seen
    logic [7:0] m_p = 8'h24;
    bit         m_ieff = 1'b1;
    bit         m_pend = 1'b0;
    bit         m_nmi_prev = 1'b1;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_step();
        bit edge_seen, i_before;
        if (!RST_N) begin
            m_p = 8'h24;
            m_ieff = 1'b1;
            m_pend = 1'b0;
        end else begin
            edge_seen = m_nmi_prev && !NMI_N;
            i_before = m_p[2];
            case (OP)
                4'd1: begin m_p[7] = ALU_N; m_p[1] = ALU_Z; end
                4'd2: begin m_p[7] = ALU_N; m_p[1] = ALU_Z; m_p[0] = ALU_C; end
                4'd3: begin m_p[7] = ALU_N; m_p[1] = ALU_Z; m_p[0] = ALU_C; m_p[6] = ALU_V; end
                4'd4: begin m_p[7] = DB_IN[7]; m_p[6] = DB_IN[6]; m_p[1] = ALU_Z; end
                4'd5: m_p = (m_p & 8'h30) | (DB_IN & 8'hCF);
                4'd6: m_p[0] = 1'b1;
                4'd7: m_p[0] = 1'b0;
                4'd8: m_p[3] = 1'b1;
                4'd9: m_p[3] = 1'b0;
                4'd10: m_p[2] = 1'b1;
                4'd11: m_p[2] = 1'b0;
                4'd12: m_p[6] = 1'b0;
                default: ;
            endcase
            if (!DEC) m_p[3] = 1'b0;
            if (INT_ACK) m_p[2] = 1'b1;
            if (INT_ACK) m_ieff = 1'b1;
            else if (SYNC) m_ieff = i_before;
            if (edge_seen) m_pend = 1'b1;
            else if (INT_ACK && m_pend) m_pend = 1'b0;
        end
        // The level seen at a reset edge is real history, so NMI held low through reset is no edge
        m_nmi_prev = NMI_N;
    endtask

    task automatic step(input logic [3:0] op, input logic [7:0] db, input logic pb,
                        input logic sync, input logic nmi, input logic irq,
                        input logic ack, input logic rst, input logic [3:0] nzcv);
        exp_t e;
        @(negedge CLK);
        OP = op; DB_IN = db; PUSH_B = pb; SYNC = sync; NMI_N = nmi; IRQ_N = irq;
        INT_ACK = ack; RST_N = rst;
        {ALU_N, ALU_Z, ALU_C, ALU_V} = nzcv;
        model_step();
        e.p   = {m_p[7:6], 1'b1, pb, m_p[3:0]};
        e.c   = m_p[0];
        e.d   = m_p[3];
        e.i   = m_p[2];
        e.src = m_pend;
        e.req = m_pend || (!irq && !m_ieff);
        exp_q.push_back(e);
    endtask

    task automatic settle();
        @(posedge CLK);
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sb_p_out",   P_OUT,   e.p);
                chk("sb_c_out",   {7'd0, C_OUT},   {7'd0, e.c});
                chk("sb_d_out",   {7'd0, D_OUT},   {7'd0, e.d});
                chk("sb_i_out",   {7'd0, I_OUT},   {7'd0, e.i});
                chk("sb_int_req", {7'd0, INT_REQ}, {7'd0, e.req});
                chk("sb_int_src", {7'd0, INT_SRC}, {7'd0, e.src});
            end
        end
    end

    initial begin : stimulus
        logic [3:0] r_op;
        logic       cur_nmi;
        step(4'd0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000);
        step(4'd6, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000);
        settle();
        chk("reset_p_out", P_OUT, 8'h34);
        chk("reset_int_req", {7'd0, INT_REQ}, 8'h00);

        step(4'd3, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'b1011);
        settle();
        chk("ld_nzcv_p_out", P_OUT, 8'hF5);

        step(4'd5, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0000);
        settle();
        chk("ld_p_p_out", P_OUT, DEC ? 8'hEF : 8'hE7);
        chk("ld_p_d_out", {7'd0, D_OUT}, {7'd0, DEC});

        step(4'd11, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000);
        settle();
        chk("cli_no_sync_i", {7'd0, I_OUT}, 8'h00);
        chk("cli_no_sync_req", {7'd0, INT_REQ}, 8'h00);
        step(4'd0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000);
        settle();
        chk("cli_sync_req", {INT_REQ, INT_SRC}, 8'h02);

        step(4'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000);
        settle();
        chk("nmi_edge_src", {INT_REQ, INT_SRC}, 8'h03);
        step(4'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000);
        settle();
        chk("nmi_ack_state", {INT_REQ, INT_SRC, I_OUT}, 8'h01);

        step(4'd0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0000);
        step(4'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0000);
        step(4'd0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0000);
        step(4'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0000);
        settle();
        chk("nmi_edge_on_ack", {7'd0, INT_SRC}, 8'h01);
        step(4'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0000);
        settle();
        chk("nmi_second_ack", {7'd0, INT_SRC}, 8'h00);
        step(4'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0000);
        settle();
        chk("idle_ack", {INT_REQ, INT_SRC, I_OUT}, 8'h01);

        step(4'd7, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0000);
        step(4'd6, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0000);
        settle();
        chk("sec_ack_ci", {C_OUT, I_OUT}, 8'h03);
        step(4'd7, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000);
        settle();
        chk("mid_reset_p_out", P_OUT, 8'h34);
        step(4'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0000);
        step(4'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0000);
        settle();
        chk("nmi_low_thru_reset", {INT_REQ, INT_SRC}, 8'h00);

        cur_nmi = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            r_op = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 5) == 0) cur_nmi = ~cur_nmi;
            step(r_op, 8'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
                 cur_nmi, 1'($urandom), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 63) != 0), 4'($urandom));
        end

        repeat (3) @(posedge CLK);
        #2;
        chk("sb_drained", 8'(exp_q.size()), 8'h00);
        stim_done = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin : watchdog
        #500000;
        if (!stim_done) begin
            n_checks++;
            n_errors++;
            $display("FAIL watchdog: got timeout expected completion");
            $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
            $finish;
        end
    end

endmodule
